// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer write path: scale codes, RGB565 pixel, FSM states.
// Default frame-buffer geometry lives here so top and bench agree on it.
package fb_pkg;

  localparam int FB_WIDTH_DEF  = 240;
  localparam int FB_HEIGHT_DEF = 320;

  typedef enum logic [1:0] {
    SCALE_1X  = 2'b00,
    SCALE_4X2 = 2'b10,
    SCALE_2X2 = 2'b11
  } scale_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    WAIT    = 1'b0,
    CAPTURE = 1'b1
  } fsm_state_e;

  // Codes 00 and 01 are both 1:1.
  function automatic scale_e decode_scale(input logic [1:0] code);
    scale_e s;
    case (code)
      2'b10:   s = SCALE_4X2;
      2'b11:   s = SCALE_2X2;
      default: s = SCALE_1X;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel-stream input and BRAM port-A write bundle of the frame-buffer writer.
// master = source/BRAM side (testbench), slave = the writer itself.
interface frame_buffer_writer_if #(
  parameter int ADDR_W = 17
);
  logic              pixel_valid_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [15:0]       pixel_data_in;
  logic              bram_we_out;
  logic [ADDR_W-1:0] bram_addr_out;
  logic [15:0]       bram_data_out;

  modport master (
    output pixel_valid_in, hcount_in, vcount_in, pixel_data_in,
    input  bram_we_out, bram_addr_out, bram_data_out
  );

  modport slave (
    input  pixel_valid_in, hcount_in, vcount_in, pixel_data_in,
    output bram_we_out, bram_addr_out, bram_data_out
  );
endinterface

// File: rtl/rgb565_avg.sv
// Per-channel floor average of two RGB565 pixels (purely combinational).
// Only compiled when FB_WRITER_AVG_EN is defined, since only then is it instantiated.
`ifdef FB_WRITER_AVG_EN
module rgb565_avg
  import fb_pkg::*;
(
  input  rgb565_t a_i,
  input  rgb565_t b_i,
  output rgb565_t avg_o
);
  logic [5:0] r_sum;
  logic [6:0] g_sum;
  logic [5:0] b_sum;

  always_comb begin
    r_sum = {1'b0, a_i.r} + {1'b0, b_i.r};
    g_sum = {1'b0, a_i.g} + {1'b0, b_i.g};
    b_sum = {1'b0, a_i.b} + {1'b0, b_i.b};
    avg_o.r = r_sum[5:1];
    avg_o.g = g_sum[6:1];
    avg_o.b = b_sum[5:1];
  end
endmodule
`endif

// File: rtl/frame_buffer_writer.sv
// Decimating raster-to-frame-buffer writer with a 2-cycle write pipeline.
// Optional FB_WRITER_AVG_EN: average kept pixel with its in-row predecessor when decimating.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int ADDR_W    = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  capture_en_in,
  input  logic [1:0]            scale_in,
  frame_buffer_writer_if.slave  pix_bus,
  output logic                  busy_out,
  output logic                  frame_done_out
);
  localparam int SH_W = $clog2(FB_WIDTH);
  localparam int SV_W = $clog2(FB_HEIGHT);

  fsm_state_e state_q, state_d;
  scale_e     scale_q, scale_d;

  logic        frame_start, capture_now, restart;
  logic        col_keep, row_keep, write_ok, last_px;
  logic [10:0] sh_full;
  logic [9:0]  sv_full;
  rgb565_t     pix_in, pix_data;

  logic            s1_we_q, s1_done_q;
  logic [SH_W-1:0] s1_sh_q;
  logic [SV_W-1:0] s1_sv_q;
  rgb565_t         s1_data_q;

  logic              we_q, done_q;
  logic [ADDR_W-1:0] addr_q, addr_calc, sv_ext;
  logic [15:0]       data_q;

  assign pix_in      = rgb565_t'(pix_bus.pixel_data_in);
  assign frame_start = pix_bus.pixel_valid_in && (pix_bus.hcount_in == 11'd0)
                       && (pix_bus.vcount_in == 10'd0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= WAIT;
      scale_q <= SCALE_1X;
    end else begin
      state_q <= state_d;
      scale_q <= scale_d;
    end
  end

  // scale_d is the scale that applies to the current pixel, so a frame-start
  // pixel is already decimated with the newly latched code.
  always_comb begin
    state_d     = state_q;
    scale_d     = scale_q;
    capture_now = 1'b0;
    restart     = 1'b0;
    case (state_q)
      WAIT: begin
        if (frame_start && capture_en_in) begin
          state_d     = CAPTURE;
          scale_d     = decode_scale(scale_in);
          capture_now = 1'b1;
        end
      end
      CAPTURE: begin
        capture_now = 1'b1;
        if (frame_start) begin
          restart = 1'b1;
          if (capture_en_in) begin
            scale_d = decode_scale(scale_in);
          end else begin
            state_d     = WAIT;
            capture_now = 1'b0;
          end
        end
      end
      default: state_d = WAIT;
    endcase

    sh_full  = pix_bus.hcount_in;
    sv_full  = pix_bus.vcount_in;
    col_keep = 1'b1;
    row_keep = 1'b1;
    case (scale_d)
      SCALE_4X2: begin
        sh_full  = {2'b00, pix_bus.hcount_in[10:2]};
        sv_full  = {1'b0, pix_bus.vcount_in[9:1]};
        col_keep = &pix_bus.hcount_in[1:0];
        row_keep = ~pix_bus.vcount_in[0];
      end
      SCALE_2X2: begin
        sh_full  = {1'b0, pix_bus.hcount_in[10:1]};
        sv_full  = {1'b0, pix_bus.vcount_in[9:1]};
        col_keep = pix_bus.hcount_in[0];
        row_keep = ~pix_bus.vcount_in[0];
      end
      default: ;
    endcase

    write_ok = pix_bus.pixel_valid_in && capture_now && col_keep && row_keep
               && (sh_full < 11'(FB_WIDTH)) && (sv_full < 10'(FB_HEIGHT));
    last_px  = write_ok && (sh_full == 11'(FB_WIDTH - 1)) && (sv_full == 10'(FB_HEIGHT - 1));
    if (last_px) state_d = WAIT;
  end

`ifdef FB_WRITER_AVG_EN
  logic    hist_valid_q;
  logic [9:0] hist_row_q;
  rgb565_t hist_data_q, avg_data;

  rgb565_avg u_avg (
    .a_i   (hist_data_q),
    .b_i   (pix_in),
    .avg_o (avg_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist_valid_q <= 1'b0;
      hist_row_q   <= '0;
      hist_data_q  <= '0;
    end else if (pix_bus.pixel_valid_in) begin
      hist_valid_q <= 1'b1;
      hist_row_q   <= pix_bus.vcount_in;
      hist_data_q  <= pix_in;
    end
  end

  always_comb begin
    pix_data = pix_in;
    if ((scale_d != SCALE_1X) && hist_valid_q && (hist_row_q == pix_bus.vcount_in))
      pix_data = avg_data;
  end
`else
  assign pix_data = pix_in;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_we_q   <= 1'b0;
      s1_done_q <= 1'b0;
      s1_sh_q   <= '0;
      s1_sv_q   <= '0;
      s1_data_q <= '0;
    end else begin
      s1_we_q   <= write_ok;
      s1_done_q <= restart || last_px;
      s1_sh_q   <= sh_full[SH_W-1:0];
      s1_sv_q   <= sv_full[SV_W-1:0];
      s1_data_q <= pix_data;
    end
  end

  // sv*240 without a multiplier.
  always_comb begin
    sv_ext    = ADDR_W'(s1_sv_q);
    addr_calc = (sv_ext << 8) - (sv_ext << 4) + ADDR_W'(s1_sh_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= s1_we_q;
      done_q <= s1_done_q;
      addr_q <= s1_we_q ? addr_calc : '0;
      data_q <= s1_we_q ? 16'(s1_data_q) : 16'h0000;
    end
  end

  assign pix_bus.bram_we_out   = we_q;
  assign pix_bus.bram_addr_out = addr_q;
  assign pix_bus.bram_data_out = data_q;
  assign frame_done_out        = done_q;
  assign busy_out              = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized bench for frame_buffer_writer against a divide/modulo reference model.
// Expected AVG data depends on whether FB_WRITER_AVG_EN is defined for the build.
module tb_frame_buffer_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture_en;
  logic [1:0] scale;
  logic       busy, frame_done;

  frame_buffer_writer_if #(.ADDR_W(17)) bus ();

  frame_buffer_writer #(.FB_WIDTH(240), .FB_HEIGHT(320), .ADDR_W(17)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .capture_en_in  (capture_en),
    .scale_in       (scale),
    .pix_bus        (bus),
    .busy_out       (busy),
    .frame_done_out (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [15:0] data;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic        m_cap;
  logic [1:0]  m_scale;
  logic        h_ok;
  int          h_row;
  logic [15:0] h_data;

  // observation bookkeeping
  int          n_wr, n_done;
  logic [16:0] last_addr;
  logic [15:0] last_data;
  logic        seen241;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] avg565(input logic [15:0] a, input logic [15:0] b);
    int r, g, bl;
    r  = (int'(a[15:11]) + int'(b[15:11])) / 2;
    g  = (int'(a[10:5])  + int'(b[10:5]))  / 2;
    bl = (int'(a[4:0])   + int'(b[4:0]))   / 2;
    return {r[4:0], g[5:0], bl[4:0]};
  endfunction

  function automatic int nh_of(input logic [1:0] s);
    return (s == 2'b10) ? 4 : (s == 2'b11) ? 2 : 1;
  endfunction

  function automatic int nv_of(input logic [1:0] s);
    return (s[1]) ? 2 : 1;
  endfunction

  task automatic model(input logic v, input int h, input int vc, input logic [15:0] d,
                       output exp_t e);
    int nh, nv, sh, sv;
    e = '0;
    if (v && h == 0 && vc == 0) begin
      if (m_cap) e.done = 1'b1;
      if (capture_en) begin
        m_cap   = 1'b1;
        m_scale = scale;
      end else begin
        m_cap = 1'b0;
      end
    end
    if (v && m_cap) begin
      nh = nh_of(m_scale);
      nv = nv_of(m_scale);
      sh = h / nh;
      sv = vc / nv;
      if ((h % nh == nh - 1) && (vc % nv == 0) && sh < 240 && sv < 320) begin
        e.we   = 1'b1;
        e.addr = 17'(sv * 240 + sh);
        e.data = d;
`ifdef FB_WRITER_AVG_EN
        if (nh > 1 && h_ok && h_row == vc) e.data = avg565(h_data, d);
`endif
        if (sv == 319 && sh == 239) begin
          e.done = 1'b1;
          m_cap  = 1'b0;
        end
      end
    end
    if (v) begin
      h_ok   = 1'b1;
      h_row  = vc;
      h_data = d;
    end
  endtask

  task automatic step(input logic v, input int h, input int vc, input logic [15:0] d);
    exp_t e;
    bus.pixel_valid_in = v;
    bus.hcount_in      = 11'(h);
    bus.vcount_in      = 10'(vc);
    bus.pixel_data_in  = d;
    model(v, h, vc, d, e);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("we", 32'(bus.bram_we_out), 32'(e.we));
    if (e.we) begin
      chk("addr", 32'(bus.bram_addr_out), 32'(e.addr));
      chk("data", 32'(bus.bram_data_out), 32'(e.data));
    end
    chk("done", 32'(frame_done), 32'(e.done));
    chk("busy", 32'(busy), 32'(m_cap));
    if (bus.bram_we_out) begin
      n_wr++;
      last_addr = bus.bram_addr_out;
      last_data = bus.bram_data_out;
      if (bus.bram_addr_out == 17'd241) seen241 = 1'b1;
    end
    if (frame_done) n_done++;
  endtask

  task automatic bubble();
    step(1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 16'($urandom));
  endtask

  task automatic flush();
    bubble();
    bubble();
  endtask

  task automatic clear_stats();
    n_wr      = 0;
    n_done    = 0;
    last_addr = '0;
    last_data = '0;
    seen241   = 1'b0;
  endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    rst                = 1'b1;
    bus.pixel_valid_in = 1'b0;
    @(negedge clk);
    chk("rst_we",   32'(bus.bram_we_out),   32'd0);
    chk("rst_addr", 32'(bus.bram_addr_out), 32'd0);
    chk("rst_data", 32'(bus.bram_data_out), 32'd0);
    chk("rst_done", 32'(frame_done),        32'd0);
    chk("rst_busy", 32'(busy),              32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(z);
    m_cap   = 1'b0;
    m_scale = 2'b00;
    h_ok    = 1'b0;
    h_row   = 0;
    h_data  = '0;
    clear_stats();
  endtask

  initial begin
    rst                = 1'b1;
    capture_en         = 1'b0;
    scale              = 2'b00;
    bus.pixel_valid_in = 1'b0;
    bus.hcount_in      = '0;
    bus.vcount_in      = '0;
    bus.pixel_data_in  = '0;

    do_reset();

    // full 1:1 frame
    capture_en = 1'b1;
    scale      = 2'b00;
    for (int v = 0; v < 320; v++)
      for (int h = 0; h < 240; h++)
        step(1'b1, h, v, 16'($urandom));
    flush();
    chk("t1_writes", 32'(n_wr), 32'd76800);
    chk("t1_dones",  32'(n_done), 32'd1);
    chk("t1_last",   32'(last_addr), 32'd76799);
    chk("t1_busy",   32'(busy), 32'd0);

    // 2x2 over a 640-wide raster, first rows only
    do_reset();
    capture_en = 1'b1;
    scale      = 2'b11;
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 640; h++)
        step(1'b1, h, v, 16'($urandom));
    flush();
    chk("t2_writes", 32'(n_wr), 32'd480);
    chk("t2_dones",  32'(n_done), 32'd0);
    chk("t2_addr241", 32'(seen241), 32'd1);

    // 4x2 corner: out-of-range column, then the very last address
    do_reset();
    capture_en = 1'b1;
    scale      = 2'b10;
    step(1'b1, 0, 0, 16'h1234);
    step(1'b1, 1279, 638, 16'hAAAA);
    step(1'b1, 959, 638, 16'h5555);
    flush();
    chk("t3_writes", 32'(n_wr), 32'd1);
    chk("t3_last",   32'(last_addr), 32'd76799);
    chk("t3_dones",  32'(n_done), 32'd1);

    // capture disabled at frame start, enabled mid-frame
    do_reset();
    capture_en = 1'b0;
    scale      = 2'b00;
    for (int h = 0; h < 50; h++) step(1'b1, h, 0, 16'($urandom));
    capture_en = 1'b1;
    for (int h = 0; h < 50; h++) step(1'b1, h, 1, 16'($urandom));
    flush();
    chk("t4_writes", 32'(n_wr), 32'd0);

    // scale change mid-frame is ignored, then reset mid-frame
    do_reset();
    capture_en = 1'b1;
    scale      = 2'b00;
    for (int h = 0; h < 10; h++) step(1'b1, h, 0, 16'($urandom));
    scale = 2'b11;
    for (int h = 0; h < 10; h++) step(1'b1, h, 1, 16'($urandom));
    flush();
    chk("t5_writes", 32'(n_wr), 32'd20);
    chk("t5_last",   32'(last_addr), 32'd249);
    for (int h = 0; h < 5; h++) step(1'b1, h, 2, 16'($urandom));
    do_reset();
    for (int h = 5; h < 21; h++) step(1'b1, h, 2, 16'($urandom));
    flush();
    chk("t5_after_rst", 32'(n_wr), 32'd0);

    // averaging pair at h=2,3 under 2x2
    do_reset();
    capture_en = 1'b1;
    scale      = 2'b11;
    step(1'b1, 0, 0, 16'h0000);
    step(1'b1, 1, 0, 16'h0000);
    step(1'b1, 2, 0, 16'hF800);
    step(1'b1, 3, 0, 16'h0000);
    flush();
`ifdef FB_WRITER_AVG_EN
    chk("t6_avg", 32'(last_data), 32'h7800);
`else
    chk("t6_avg", 32'(last_data), 32'h0000);
`endif

    // random frames with bubbles, scale/enable changes and end-of-frame jumps
    do_reset();
    for (int f = 0; f < 8; f++) begin
      int rows, width, nh, nv;
      scale      = 2'($urandom_range(0, 3));
      capture_en = ($urandom_range(0, 3) != 0);
      rows       = int'($urandom_range(1, 3));
      width      = int'($urandom_range(8, 200));
      for (int v = 0; v < rows; v++) begin
        if ($urandom_range(0, 3) == 0) scale = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) capture_en = ~capture_en;
        for (int h = 0; h < width; h++) begin
          if ($urandom_range(0, 4) == 0) bubble();
          step(1'b1, h, v, 16'($urandom));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        nh = nh_of(m_scale);
        nv = nv_of(m_scale);
        for (int h = 239 * nh - 2; h <= 239 * nh + nh + 1; h++) begin
          if ($urandom_range(0, 3) == 0) bubble();
          step(1'b1, h, 319 * nv, 16'($urandom));
        end
      end
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
